// File: rtl/alu_hilo.sv
// alu_hilo: execute-stage ALU with a HI/LO multiply unit.
//
// Single-cycle ops (add, sub, and, or, slt) are purely combinational.
// multu runs as a fixed-latency shift-add multiplier over WIDTH cycles and
// writes the 2*WIDTH-bit product to HI/LO. mfhi/mflo read those registers.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   op_valid      EX stage holds a valid instruction this cycle
//   ALUOperation  6-bit op code (32 add, 34 sub, 36 and, 37 or, 42 slt,
//                 25 multu, 16 mfhi, 18 mflo)
//   A, B          operands (rs, rt/immediate)
//   Result        combinational result
//   Zero          Result == 0
//   Stall         hold EX and earlier stages this cycle
//   Busy          multiply in progress (registered)
module alu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [5:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Stall,
  output logic             Busy
);

  localparam logic [5:0] OP_ADD   = 6'd32;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_OR    = 6'd37;
  localparam logic [5:0] OP_SLT   = 6'd42;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MFLO  = 6'd18;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Control state (reset)
  state_t                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;

  // Multiplier datapath (not reset; always loaded on accept before use)
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [2*WIDTH-1:0]     acc_step;

  logic                   accept;
  logic                   hilo_dep;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  assign a_s = A;
  assign b_s = B;

  // Ops that depend on the multiplier: a new multu or a HI/LO read.
  assign hilo_dep = (ALUOperation == OP_MULTU) ||
                    (ALUOperation == OP_MFHI)  ||
                    (ALUOperation == OP_MFLO);

  assign Stall  = op_valid && busy_q && hilo_dep;
  assign accept = op_valid && (ALUOperation == OP_MULTU) && !busy_q;
  assign Busy   = busy_q;

  // One shift-add step; also used for the final write so the last
  // partial product lands in HI/LO on the completing edge.
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mcand_d  = {{WIDTH{1'b0}}, A};
          mplier_d = B;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_MUL;
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          {hi_d, lo_d} = acc_step;
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
  end

  always_comb begin
    Result = '0;
    case (ALUOperation)
      OP_ADD:  Result = A + B;
      OP_SUB:  Result = A - B;
      OP_AND:  Result = A & B;
      OP_OR:   Result = A | B;
      OP_SLT:  Result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      // A stalled HI/LO read must not forward a stale value.
      OP_MFHI: Result = Stall ? '0 : hi_q;
      OP_MFLO: Result = Stall ? '0 : lo_q;
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule
